// File: rtl/yd_wb_arb.sv
// -----------------------------------------------------------------------------
// yd_wb_arb : write-back arbiter for the 16-entry register file.
//
// Shares the register file's two write ports between three requesters
// (0 = ALU, 1 = load/store, 2 = multiply/divide). Each cycle at most two
// writes to distinct addresses are issued, chosen by a rotating priority
// pointer with an anti-starvation override. Writes to address 0 (ZE) are
// accepted immediately and discarded without consuming a port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hold              pipeline stall, blocks every grant
//   req_valid[2:0]    per-requester write request
//   req_addr          requester i at [i*AW +: AW]
//   req_data          requester i at [i*DW +: DW]
//   req_ready[2:0]    combinational accept (transfer = valid & ready)
//   we0/waddr0/din0   registered write port 0
//   we1/waddr1/din1   registered write port 1
//   jpc               registered: an issued write targets the PC (all ones)
//   starved[2:0]      registered: requester's wait counter is at MAXWAIT
// -----------------------------------------------------------------------------
module yd_wb_arb #(
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter int MAXWAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic [2:0]      req_valid,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_ready,
  output logic            we0,
  output logic [AW-1:0]   waddr0,
  output logic [DW-1:0]   din0,
  output logic            we1,
  output logic [AW-1:0]   waddr1,
  output logic [DW-1:0]   din1,
  output logic            jpc,
  output logic [2:0]      starved
);

  localparam logic [3:0]    MAXW    = 4'(MAXWAIT);
  localparam logic [AW-1:0] PC_ADDR = {AW{1'b1}};

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0]    ptr_q, ptr_d;
  logic [2:0]    starved_q, starved_d;
  logic [3:0]    wait_q [3];
  logic [3:0]    wait_d [3];
  logic [AW-1:0] addr_a [3];
  logic [DW-1:0] data_a [3];

  logic          we0_q, we1_q, jpc_q;
  logic [AW-1:0] waddr0_q, waddr1_q;
  logic [DW-1:0] din0_q, din1_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign addr_a[gi] = req_addr[gi*AW +: AW];
      assign data_a[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Candidate order: starved requesters first (ascending index), then the
  // remaining ones in rotation order starting at ptr.
  logic [1:0] order [3];
  logic [1:0] ord_k, rot_r;

  always_comb begin
    ord_k = 2'd0;
    rot_r = ptr_q;
    for (int i = 0; i < 3; i++) order[i] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (starved_q[i]) begin
        order[ord_k] = 2'(i);
        ord_k        = ord_k + 2'd1;
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (!starved_q[rot_r]) begin
        order[ord_k] = rot_r;
        ord_k        = ord_k + 2'd1;
      end
      rot_r = inc3(rot_r);
    end
  end

  // Port assignment walks the candidate order once.
  logic          p0_v, p1_v;
  logic [1:0]    p0_idx, p1_idx, cand;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_data, p1_data;

  always_comb begin
    req_ready = 3'b000;
    p0_v      = 1'b0;
    p1_v      = 1'b0;
    p0_idx    = 2'd0;
    p1_idx    = 2'd0;
    p0_addr   = '0;
    p1_addr   = '0;
    p0_data   = '0;
    p1_data   = '0;
    cand      = 2'd0;
    for (int j = 0; j < 3; j++) begin
      cand = order[j];
      if (!hold && req_valid[cand]) begin
        if (addr_a[cand] == '0) begin
          // ZE writes are swallowed without using a port.
          req_ready[cand] = 1'b1;
        end else if (!p0_v) begin
          p0_v            = 1'b1;
          p0_idx          = cand;
          p0_addr         = addr_a[cand];
          p0_data         = data_a[cand];
          req_ready[cand] = 1'b1;
        end else if (!p1_v && (addr_a[cand] != p0_addr)) begin
          p1_v            = 1'b1;
          p1_idx          = cand;
          p1_addr         = addr_a[cand];
          p1_data         = data_a[cand];
          req_ready[cand] = 1'b1;
        end
      end
    end
  end

  // Pointer moves past the last non-ZE grantee; hold leaves p0_v low.
  always_comb begin
    ptr_d = ptr_q;
    if (p1_v)      ptr_d = inc3(p1_idx);
    else if (p0_v) ptr_d = inc3(p0_idx);
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_wait
      always_comb begin
        wait_d[gi] = 4'd0;
        if (hold) begin
          wait_d[gi] = wait_q[gi];
        end else if (req_valid[gi] && !req_ready[gi] && (addr_a[gi] != '0)) begin
          wait_d[gi] = (wait_q[gi] >= MAXW) ? MAXW : wait_q[gi] + 4'd1;
        end
      end
      assign starved_d[gi] = (wait_d[gi] == MAXW);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wait_q[gi]    <= 4'd0;
          starved_q[gi] <= 1'b0;
        end else begin
          wait_q[gi]    <= wait_d[gi];
          starved_q[gi] <= starved_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= 2'd0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      jpc_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      din0_q   <= '0;
      din1_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      we0_q <= p0_v;
      we1_q <= p1_v;
      jpc_q <= (p0_v && (p0_addr == PC_ADDR)) || (p1_v && (p1_addr == PC_ADDR));
      // An idle port keeps its last address/data.
      if (p0_v) begin
        waddr0_q <= p0_addr;
        din0_q   <= p0_data;
      end
      if (p1_v) begin
        waddr1_q <= p1_addr;
        din1_q   <= p1_data;
      end
    end
  end

  assign we0     = we0_q;
  assign waddr0  = waddr0_q;
  assign din0    = din0_q;
  assign we1     = we1_q;
  assign waddr1  = waddr1_q;
  assign din1    = din1_q;
  assign jpc     = jpc_q;
  assign starved = starved_q;

endmodule

// File: tb/tb_yd_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_yd_wb_arb : directed self-checking bench for yd_wb_arb.
// Inputs change 1 time unit after the rising edge; combinational ready is
// sampled 1 unit later, registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_yd_wb_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [11:0] req_addr = '0;
  logic [47:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        we0, we1, jpc;
  logic [3:0]  waddr0, waddr1;
  logic [15:0] din0, din1;
  logic [2:0]  starved;

  int checks = 0;
  int errors = 0;

  yd_wb_arb #(.DW(16), .AW(4), .MAXWAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we0       (we0),
    .waddr0    (waddr0),
    .din0      (din0),
    .we1       (we1),
    .waddr1    (waddr1),
    .din1      (din1),
    .jpc       (jpc),
    .starved   (starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [15:0] d);
    req_valid[i]          = v;
    req_addr[i*4 +: 4]    = a;
    req_data[i*16 +: 16]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t we0=%0b a0=%0h d0=%0h we1=%0b a1=%0h d1=%0h jpc=%0b starved=%03b",
             $time, we0, waddr0, din0, we1, waddr1, din1, jpc, starved);
    // Never two writes to the same register in one cycle.
    if (we0 && we1) check("dual_same_addr", {31'd0, waddr0 == waddr1}, 32'd0);
  endtask

  task automatic check_ports(input string tag, input logic e0, input logic [3:0] a0,
                             input logic [15:0] d0, input logic e1, input logic [3:0] a1,
                             input logic [15:0] d1, input logic ej);
    check({tag, "_we0"}, {31'd0, we0}, {31'd0, e0});
    if (e0) begin
      check({tag, "_waddr0"}, {28'd0, waddr0}, {28'd0, a0});
      check({tag, "_din0"},   {16'd0, din0},   {16'd0, d0});
    end
    check({tag, "_we1"}, {31'd0, we1}, {31'd0, e1});
    if (e1) begin
      check({tag, "_waddr1"}, {28'd0, waddr1}, {28'd0, a1});
      check({tag, "_din1"},   {16'd0, din1},   {16'd0, d1});
    end
    check({tag, "_jpc"}, {31'd0, jpc}, {31'd0, ej});
  endtask

  logic [2:0] rot_rdy [3];
  logic [3:0] rot_a0  [3];
  logic [3:0] rot_a1  [3];

  initial begin
    rot_rdy = '{3'b110, 3'b011, 3'b101};
    rot_a0  = '{4'd8, 4'd1, 4'd12};
    rot_a1  = '{4'd12, 4'd8, 4'd1};

    // Reset state
    #2;
    check("rst_we0", {31'd0, we0}, 32'd0);
    check("rst_waddr0", {28'd0, waddr0}, 32'd0);
    check("rst_din0", {16'd0, din0}, 32'd0);
    check("rst_we1", {31'd0, we1}, 32'd0);
    check("rst_jpc", {31'd0, jpc}, 32'd0);
    check("rst_starved", {29'd0, starved}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single ALU write (ptr 0 -> 1)
    set_req(0, 1'b1, 4'd2, 16'h1234);
    #1 check("alu_rdy", {29'd0, req_ready}, 32'b001);
    tick();
    check_ports("alu", 1'b1, 4'd2, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0);
    set_req(0, 1'b0, 4'd0, 16'd0);

    // Single MUL write (ptr 1 -> 0)
    set_req(2, 1'b1, 4'd9, 16'h9999);
    #1 check("mul_rdy", {29'd0, req_ready}, 32'b100);
    tick();
    check_ports("mul", 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'd0, 1'b0);
    set_req(2, 1'b0, 4'd0, 16'd0);

    // Dual write at ptr 0 (ptr -> 2)
    set_req(0, 1'b1, 4'd3, 16'hAAAA);
    set_req(1, 1'b1, 4'd4, 16'h5555);
    #1 check("dual_rdy", {29'd0, req_ready}, 32'b011);
    tick();
    check_ports("dual", 1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd4, 16'h5555, 1'b0);
    set_req(0, 1'b0, 4'd0, 16'd0);
    set_req(1, 1'b0, 4'd0, 16'd0);

    // Same-address conflict at ptr 2: MUL first, ALU next cycle
    set_req(0, 1'b1, 4'd5, 16'h0A0A);
    set_req(2, 1'b1, 4'd5, 16'h0C0C);
    #1 check("conf_rdy1", {29'd0, req_ready}, 32'b100);
    tick();
    check_ports("conf1", 1'b1, 4'd5, 16'h0C0C, 1'b0, 4'd0, 16'd0, 1'b0);
    set_req(2, 1'b0, 4'd0, 16'd0);
    #1 check("conf_rdy2", {29'd0, req_ready}, 32'b001);
    tick();
    check_ports("conf2", 1'b1, 4'd5, 16'h0A0A, 1'b0, 4'd0, 16'd0, 1'b0);
    set_req(0, 1'b0, 4'd0, 16'd0);

    // PC write plus ZE write at ptr 1 (ptr -> 2)
    set_req(1, 1'b1, 4'd15, 16'h0040);
    set_req(0, 1'b1, 4'd0, 16'hFFFF);
    #1 check("pc_rdy", {29'd0, req_ready}, 32'b011);
    tick();
    check_ports("pc", 1'b1, 4'd15, 16'h0040, 1'b0, 4'd0, 16'd0, 1'b1);
    set_req(0, 1'b0, 4'd0, 16'd0);
    set_req(1, 1'b0, 4'd0, 16'd0);

    // Hold with all three valid, ptr frozen at 2
    hold = 1'b1;
    set_req(0, 1'b1, 4'd1, 16'h1111);
    set_req(1, 1'b1, 4'd8, 16'h2222);
    set_req(2, 1'b1, 4'd12, 16'h3333);
    for (int c = 0; c < 6; c++) begin
      #1 check("hold_rdy", {29'd0, req_ready}, 32'b000);
      tick();
      check_ports("hold", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
      check("hold_starved", {29'd0, starved}, 32'd0);
    end
    hold = 1'b0;
    #1 check("unhold_rdy", {29'd0, req_ready}, 32'b101);
    tick();
    check_ports("unhold", 1'b1, 4'd12, 16'h3333, 1'b1, 4'd1, 16'h1111, 1'b0);

    // Continuous three-way contention, rotation from ptr 1
    for (int c = 0; c < 12; c++) begin
      #1 check("rot_rdy", {29'd0, req_ready}, {29'd0, rot_rdy[c % 3]});
      tick();
      check("rot_a0", {28'd0, waddr0}, {28'd0, rot_a0[c % 3]});
      check("rot_a1", {28'd0, waddr1}, {28'd0, rot_a1[c % 3]});
      check("rot_starved", {29'd0, starved}, 32'd0);
    end

    // Starve MUL: LSU and MUL share address 6 at ptr 1
    set_req(0, 1'b1, 4'd7, 16'h7777);
    set_req(1, 1'b1, 4'd6, 16'h6666);
    set_req(2, 1'b1, 4'd6, 16'hC6C6);
    for (int c = 0; c < 4; c++) begin
      #1 check("stv_rdy", {29'd0, req_ready}, 32'b011);
      tick();
      check_ports("stv", 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7777, 1'b0);
      check("stv_starved", {29'd0, starved}, (c == 3) ? 32'b100 : 32'b000);
    end
    #1 check("stv_win_rdy", {29'd0, req_ready}, 32'b101);
    tick();
    check_ports("stv_win", 1'b1, 4'd6, 16'hC6C6, 1'b1, 4'd7, 16'h7777, 1'b0);
    check("stv_clear", {29'd0, starved}, 32'd0);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    check("arst_we0", {31'd0, we0}, 32'd0);
    check("arst_waddr0", {28'd0, waddr0}, 32'd0);
    check("arst_din0", {16'd0, din0}, 32'd0);
    check("arst_we1", {31'd0, we1}, 32'd0);
    check("arst_waddr1", {28'd0, waddr1}, 32'd0);
    check("arst_din1", {16'd0, din1}, 32'd0);
    check("arst_jpc", {31'd0, jpc}, 32'd0);
    check("arst_starved", {29'd0, starved}, 32'd0);
    tick();
    rst = 1'b0;
    req_valid = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
